// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the ALU result (requester 0) and load data (requester 1). It drives the
// select line of the shared address/data muxes and registers the winning
// write into a one-cycle stage that feeds the register file.
module wb_port_arbiter #(
  parameter int AW        = 5,
  parameter int DW        = 64,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          wb_stall,
  output logic          mux_sel,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  // PRI0 favours requester 0 on a tie (requester 1 was granted last),
  // PRI1 favours requester 1 (requester 0 was granted last).
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic          w_block;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_transfer;
  logic          r_muxSel;
  logic          w_muxSel;
  logic [AW-1:0] w_muxAddr;
  logic [DW-1:0] w_muxData;
  logic          r_rfWe;
  logic [AW-1:0] r_rfWaddr;
  logic [DW-1:0] r_rfWdata;

  // No grant may be issued while the register file is stalled or in reset.
  assign w_block = rst | wb_stall;

  // Grant decision and tie-break state update; a grant always implies valid,
  // so a grant is itself a transfer and moves the tie-break state.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_stateNext = r_state;
    if (!w_block) begin
      if (FIXED_PRI != 0) begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid & ~req0_valid;
      end else if (req0_valid && req1_valid) begin
        w_gnt0 = (r_state == PRI0);
        w_gnt1 = (r_state == PRI1);
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
    if (w_gnt0) begin
      w_stateNext = PRI1;
    end else if (w_gnt1) begin
      w_stateNext = PRI0;
    end
  end

  // Mux select follows the winner and otherwise holds, so idle cycles do not
  // toggle the shared muxes; it is forced to requester 0 while in reset.
  always_comb begin
    w_muxSel = r_muxSel;
    if (rst) begin
      w_muxSel = 1'b0;
    end else if (w_gnt1) begin
      w_muxSel = 1'b1;
    end else if (w_gnt0) begin
      w_muxSel = 1'b0;
    end
  end

  assign w_transfer = w_gnt0 | w_gnt1;
  assign w_muxAddr  = w_muxSel ? req1_addr : req0_addr;
  assign w_muxData  = w_muxSel ? req1_data : req0_data;

  // Tie-break state and held mux select; reset makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PRI0;
      r_muxSel <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_muxSel <= w_muxSel;
    end
  end

  // One-cycle write stage: pulses the enable per transfer and holds address/data otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rfWe    <= 1'b0;
      r_rfWaddr <= '0;
      r_rfWdata <= '0;
    end else begin
      r_rfWe <= w_transfer;
      if (w_transfer) begin
        r_rfWaddr <= w_muxAddr;
        r_rfWdata <= w_muxData;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign mux_sel    = w_muxSel;
  assign rf_we      = r_rfWe;
  assign rf_waddr   = r_rfWaddr;
  assign rf_wdata   = r_rfWdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: a round-robin and a fixed-priority instance
// share the same stimulus and are both compared every cycle against a
// behavioural model of the arbitration rules.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        req0Valid;
  logic [4:0]  req0Addr;
  logic [63:0] req0Data;
  logic        req1Valid;
  logic [4:0]  req1Addr;
  logic [63:0] req1Data;
  logic        wbStall;

  logic        rrReady0, rrReady1, rrSel, rrWe;
  logic [4:0]  rrWaddr;
  logic [63:0] rrWdata;
  logic        fpReady0, fpReady1, fpSel, fpWe;
  logic [4:0]  fpWaddr;
  logic [63:0] fpWdata;

  int checks = 0;
  int errors = 0;

  // Model state per instance (0 = round robin, 1 = fixed priority)
  int          mLastGnt [2];
  int          mLastSel [2];
  logic        mWe      [2];
  logic [4:0]  mAddr    [2];
  logic [63:0] mData    [2];

  wb_port_arbiter #(.AW(5), .DW(64), .FIXED_PRI(0)) dutRr (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_addr(req0Addr), .req0_data(req0Data), .req0_ready(rrReady0),
    .req1_valid(req1Valid), .req1_addr(req1Addr), .req1_data(req1Data), .req1_ready(rrReady1),
    .wb_stall(wbStall), .mux_sel(rrSel),
    .rf_we(rrWe), .rf_waddr(rrWaddr), .rf_wdata(rrWdata)
  );

  wb_port_arbiter #(.AW(5), .DW(64), .FIXED_PRI(1)) dutFp (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_addr(req0Addr), .req0_data(req0Data), .req0_ready(fpReady0),
    .req1_valid(req1Valid), .req1_addr(req1Addr), .req1_data(req1Data), .req1_ready(fpReady1),
    .wb_stall(wbStall), .mux_sel(fpSel),
    .rf_we(fpWe), .rf_waddr(fpWaddr), .rf_wdata(fpWdata)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Winner under the arbitration rules: -1 none, 0 or 1 otherwise
  function automatic int modelGrant(input int m);
    if (rst || wbStall) return -1;
    if (m == 1) begin
      if (req0Valid) return 0;
      if (req1Valid) return 1;
      return -1;
    end
    if (req0Valid && req1Valid) return (mLastGnt[m] == 0) ? 1 : 0;
    if (req0Valid) return 0;
    if (req1Valid) return 1;
    return -1;
  endfunction

  // Compare one instance against the model, then advance the model across the next rising edge
  task automatic checkInstance(input int m, input logic r0, input logic r1, input logic sel,
                               input logic we, input logic [4:0] waddr, input logic [63:0] wdata);
    int   g;
    int   expSel;
    g      = modelGrant(m);
    expSel = rst ? 0 : ((g >= 0) ? g : mLastSel[m]);
    checkOutput($sformatf("m%0d ready0", m), {63'd0, r0}, {63'd0, (g == 0)});
    checkOutput($sformatf("m%0d ready1", m), {63'd0, r1}, {63'd0, (g == 1)});
    checkOutput($sformatf("m%0d mux_sel", m), {63'd0, sel}, 64'(expSel));
    checkOutput($sformatf("m%0d rf_we", m), {63'd0, we}, {63'd0, mWe[m]});
    checkOutput($sformatf("m%0d rf_waddr", m), {59'd0, waddr}, {59'd0, mAddr[m]});
    checkOutput($sformatf("m%0d rf_wdata", m), wdata, mData[m]);
    if (rst) begin
      mLastGnt[m] = 1;
      mLastSel[m] = 0;
      mWe[m]      = 1'b0;
      mAddr[m]    = '0;
      mData[m]    = '0;
    end else begin
      mWe[m] = (g >= 0);
      if (g == 0) begin
        mAddr[m] = req0Addr;
        mData[m] = req0Data;
      end else if (g == 1) begin
        mAddr[m] = req1Addr;
        mData[m] = req1Data;
      end
      if (g >= 0) mLastGnt[m] = g;
      mLastSel[m] = expSel;
    end
  endtask

  // Every falling edge both instances are checked against the model
  always @(negedge clk) begin
    checkInstance(0, rrReady0, rrReady1, rrSel, rrWe, rrWaddr, rrWdata);
    checkInstance(1, fpReady0, fpReady1, fpSel, fpWe, fpWaddr, fpWdata);
  end

  // Drive one cycle of inputs just after the rising edge
  task automatic applyStimulus(input logic r, input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [63:0] d1, input logic s);
    @(posedge clk);
    #1;
    rst       = r;
    req0Valid = v0;
    req0Addr  = a0;
    req0Data  = d0;
    req1Valid = v1;
    req1Addr  = a1;
    req1Data  = d1;
    wbStall   = s;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mLastGnt[m] = 1;
      mLastSel[m] = 0;
      mWe[m]      = 1'b0;
      mAddr[m]    = '0;
      mData[m]    = '0;
    end
    rst       = 1'b1;
    req0Valid = 1'b0;
    req0Addr  = '0;
    req0Data  = '0;
    req1Valid = 1'b0;
    req1Addr  = '0;
    req1Data  = '0;
    wbStall   = 1'b0;

    // Reset then idle
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Single requester 1 write
    applyStimulus(0, 0, 0, 0, 1, 5'd7, 64'hDEAD_BEEF_0000_0001, 0);
    @(negedge clk);
    checkOutput("single ready1", {63'd0, rrReady1}, 64'd1);
    checkOutput("single mux_sel", {63'd0, rrSel}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("single rf_we", {63'd0, rrWe}, 64'd1);
    checkOutput("single rf_waddr", {59'd0, rrWaddr}, 64'd7);
    checkOutput("single rf_wdata", rrWdata, 64'hDEAD_BEEF_0000_0001);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("single rf_we drop", {63'd0, rrWe}, 64'd0);

    // Contention: round robin alternates, fixed priority stays on requester 0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 0);
      @(negedge clk);
      checkOutput($sformatf("rr grant%0d", i), {63'd0, rrReady1}, 64'(i % 2));
      checkOutput($sformatf("fp grant%0d", i), {63'd0, fpReady0}, 64'd1);
    end
    applyStimulus(0, 0, 5'd3, 64'h33, 1, 5'd4, 64'h44, 0);
    @(negedge clk);
    checkOutput("rr last addr", {59'd0, rrWaddr}, 64'd4);
    checkOutput("fp req1 after drop", {63'd0, fpReady1}, 64'd1);

    // Stall: requester 0 granted, then three stalled cycles, then requester 1
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5'd9, 64'h99, 1, 5'd10, 64'hAA, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 5'd10, 64'hAA, 1);
      @(negedge clk);
      checkOutput($sformatf("stall ready1 %0d", i), {63'd0, rrReady1}, 64'd0);
      if (i == 0) checkOutput("stall addr9", {59'd0, rrWaddr}, 64'd9);
    end
    applyStimulus(0, 0, 0, 0, 1, 5'd10, 64'hAA, 0);
    @(negedge clk);
    checkOutput("stall resume ready1", {63'd0, rrReady1}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("stall resume addr", {59'd0, rrWaddr}, 64'd10);

    // Reset asserted while requester 0 is valid
    applyStimulus(1, 1, 5'd12, 64'hC, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rst ready0", {63'd0, rrReady0}, 64'd0);
    applyStimulus(0, 1, 5'd12, 64'hC, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post rst rf_we", {63'd0, rrWe}, 64'd0);
    checkOutput("post rst ready0", {63'd0, rrReady0}, 64'd1);

    // Randomized traffic with occasional stalls and resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                    1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 4) == 0));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: requester 0 (ALU/execute result) and requester 1 (load data).
- Arbitrates each cycle and drives the select line of the existing 5-bit address 2:1 mux and 64-bit data 2:1 mux.
- Registers the winning address/data into a one-cycle write stage feeding the register file.
- Uses a valid/ready handshake per requester, so a loser simply holds its request.

Parameters:
- AW, 5, register address width (matches 5-bit address mux).
- DW, 64, write data width (matches 64-bit data mux).
- FIXED_PRI, 0, arbitration mode: 0 = round robin, 1 = requester 0 always wins.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  AW  requester 0 destination register.
- req0_data  input  DW  requester 0 write data.
- req0_ready  output  1  requester 0 granted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  AW  requester 1 destination register.
- req1_data  input  DW  requester 1 write data.
- req1_ready  output  1  requester 1 granted this cycle (combinational).
- wb_stall  input  1  register file cannot accept a write; blocks new grants.
- mux_sel  output  1  combinational select to address/data muxes: 0 = req0, 1 = req1.
- rf_we  output  1  registered register-file write enable.
- rf_waddr  output  AW  registered write address.
- rf_wdata  output  DW  registered write data.

Behaviour:
- Transfer: occurs when reqN_valid & reqN_ready. At most one ready is high per cycle.
- Ready is never high when wb_stall=1 or rst=1.
- Grant, FIXED_PRI=0:
  - Only one valid: that requester wins.
  - Both valid: the requester not granted most recently wins.
  - last_gnt register updates only on a transfer.
- Grant, FIXED_PRI=1: req0 wins whenever req0_valid; req1 wins only if req0_valid=0.
- mux_sel:
  - Equals the winner in a cycle with a grant.
  - With no grant, holds the last winner (avoids needless mux toggling).
- Latency: exactly 1 cycle. On a transfer, rf_we=1 next cycle, and rf_waddr/rf_wdata take the muxed values.
- rf_we is a single-cycle pulse per transfer. Back-to-back transfers give rf_we high on consecutive cycles.
- Cycles with no transfer: rf_we=0; rf_waddr/rf_wdata hold their previous values.
- Address 0 is not special here; the register file handles any r0 rules.
- Stall: no new grants while wb_stall=1. A write already captured in the output stage still issues (rf_we pulses once). Arbitration resumes the cycle wb_stall falls, with last_gnt unchanged.
- Simultaneous requests to the same address: the write order follows the grant order; no merging.
- Reset (also mid-operation):
  - rf_we=0, rf_waddr=0, rf_wdata=0, mux_sel=0.
  - last_gnt=1, so req0 wins the first tie.
  - Both ready outputs are 0 during rst; pending requests are not consumed and must be held by the requesters.
  - A write captured in the cycle rst is sampled is discarded.
- Internal states (FIXED_PRI=0):
  - PRI0: last_gnt=1, req0 favoured.
  - PRI1: last_gnt=0, req1 favoured.
  - Transition PRI0->PRI1 on a req0 transfer; PRI1->PRI0 on a req1 transfer; otherwise hold.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, no valids.
  - Required: rf_we=0, rf_waddr=0, rf_wdata=0, mux_sel=0, both readys 0 throughout.
- Single requester:
  - Stimulus: req1_valid=1, addr=5'd7, data=64'hDEAD_BEEF_0000_0001 for one cycle.
  - Required: req1_ready=1 and mux_sel=1 that cycle; next cycle rf_we=1, rf_waddr=7, rf_wdata=64'hDEAD_BEEF_0000_0001; the cycle after, rf_we=0.
- Round-robin contention:
  - Stimulus: both valid continuously for 4 cycles, req0 addr 3, req1 addr 4.
  - Required: grants alternate 0,1,0,1; rf_waddr sequence 3,4,3,4 with rf_we high 4 consecutive cycles.
- Fixed priority:
  - Stimulus: FIXED_PRI=1, both valid for 3 cycles, then req0 drops.
  - Required: req0 granted cycles 1-3, req1 granted cycle 4.
- Stall:
  - Stimulus: grant req0 (addr 9) in cycle N, wb_stall=1 from N+1 to N+3, req1 valid throughout.
  - Required: rf_we=1 at N+1 with addr 9; no ready during N+1..N+3; req1 granted at N+4, written at N+5.
- Reset mid-operation:
  - Stimulus: rst asserted in the same cycle req0 is valid.
  - Required: req0_ready=0; rf_we=0 the next cycle; req0 granted on the first cycle after rst deasserts.
